// File: rtl/vr_rr_arbiter_if.sv
// Valid/ready bundle between N producer channels, the arbiter and one consumer.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface vr_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_rdy;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [IDW-1:0]     out_id;
    logic               out_rdy;

    modport master (
        output in_valid, in_data, out_rdy,
        input  in_rdy, out_valid, out_data, out_id
    );

    modport slave (
        input  in_valid, in_data, out_rdy,
        output in_rdy, out_valid, out_data, out_id
    );
endinterface

// File: rtl/vr_rr_arbiter.sv
// Round-robin merge of N valid/ready channels onto one registered output,
// with an optional burst lock that keeps the grant on one channel for up to
// BURST consecutive beats. The output register drains and reloads in the same
// cycle, so a continuously ready consumer sees one beat per clock.
module vr_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int BURST = 1
) (
    input  logic           clk,
    input  logic           rst,
    vr_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(BURST + 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [IDW-1:0]   r_out_id;
    logic [IDW-1:0]   r_last;
    logic [CW-1:0]    r_cnt;
    logic             r_lock;

    logic             w_can_load;
    logic [N-1:0]     w_hi_mask;
    logic [N-1:0]     w_hi_req;
    logic [IDW-1:0]   w_grant;
    logic             w_grant_vld;
    logic [N-1:0]     w_rdy;
    logic             w_accept;
    logic [CW-1:0]    w_cnt_next;
    logic             w_lock_next;

    // Lowest-index set bit of a request vector.
    function automatic logic [IDW-1:0] f_lowest(input logic [N-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    assign w_can_load = !r_out_valid || bus.out_rdy;
    assign w_hi_req   = bus.in_valid & w_hi_mask;

    // Channels strictly above the last grant come first in the rotation.
    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_hi_mask[i] = (i > int'(r_last));
        end
    end

    // Grant: held channel while locked and still valid, else rotate past last.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        if (r_lock && bus.in_valid[r_last]) begin
            w_grant     = r_last;
            w_grant_vld = 1'b1;
        end else if (|w_hi_req) begin
            w_grant     = f_lowest(w_hi_req);
            w_grant_vld = 1'b1;
        end else if (|bus.in_valid) begin
            w_grant     = f_lowest(bus.in_valid);
            w_grant_vld = 1'b1;
        end
    end

    // One-hot ready to the granted channel only when the output can take it.
    always_comb begin
        w_rdy = '0;
        if (!rst && w_can_load && w_grant_vld) begin
            w_rdy[w_grant] = 1'b1;
        end
    end

    assign w_accept    = |w_rdy;
    assign w_cnt_next  = (r_lock && (w_grant == r_last)) ? (r_cnt + CW'(1)) : CW'(1);
    assign w_lock_next = (int'(w_cnt_next) < BURST);

    // Output register, rotation pointer and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_last      <= IDW'(N - 1);
            r_cnt       <= '0;
            r_lock      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data[int'(w_grant)*WIDTH +: WIDTH];
            r_out_id    <= w_grant;
            r_last      <= w_grant;
            r_cnt       <= w_cnt_next;
            r_lock      <= w_lock_next;
        end else if (bus.out_rdy) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_rdy    = w_rdy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Bench for vr_rr_arbiter: a BURST=1 and a BURST=3 instance side by side,
// each compared every cycle against a rule-level model of the arbiter,
// with directed scenarios followed by randomized traffic and backpressure.
module tb_vr_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic rst;

    logic [N-1:0]   s_valid [2];
    logic [N*W-1:0] s_data  [2];
    logic           s_ordy  [2];

    logic [N-1:0]   o_rdy [2];
    logic           o_ov  [2];
    logic [W-1:0]   o_od  [2];
    logic [1:0]     o_id  [2];

    vr_rr_arbiter_if #(.WIDTH(W), .N(N)) bus1 ();
    vr_rr_arbiter_if #(.WIDTH(W), .N(N)) bus3 ();

    assign bus1.in_valid = s_valid[0];
    assign bus1.in_data  = s_data[0];
    assign bus1.out_rdy  = s_ordy[0];
    assign bus3.in_valid = s_valid[1];
    assign bus3.in_data  = s_data[1];
    assign bus3.out_rdy  = s_ordy[1];

    assign o_rdy[0] = bus1.in_rdy;
    assign o_ov[0]  = bus1.out_valid;
    assign o_od[0]  = bus1.out_data;
    assign o_id[0]  = bus1.out_id;
    assign o_rdy[1] = bus3.in_rdy;
    assign o_ov[1]  = bus3.out_valid;
    assign o_od[1]  = bus3.out_data;
    assign o_id[1]  = bus3.out_id;

    vr_rr_arbiter #(.WIDTH(W), .N(N), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    vr_rr_arbiter #(.WIDTH(W), .N(N), .BURST(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, in the terms the arbiter rules are written in.
    int           m_burst [2] = '{1, 3};
    int           m_last  [2];
    int           m_cnt   [2];
    bit           m_lock  [2];
    bit           m_ov    [2];
    logic [W-1:0] m_od    [2];
    int           m_oid   [2];
    int           acc     [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic int mgrant(input int k);
        int ch;
        if (m_lock[k] && s_valid[k][m_last[k]]) return m_last[k];
        for (int off = 1; off <= N; off++) begin
            ch = (m_last[k] + off) % N;
            if (s_valid[k][ch]) return ch;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy(input int k);
        logic [N-1:0] r;
        int g;
        r = '0;
        g = mgrant(k);
        if (!rst && (!m_ov[k] || s_ordy[k]) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int g;
        for (int k = 0; k < 2; k++) begin
            acc[k] = -1;
            if (rst) begin
                m_last[k] = N - 1;
                m_cnt[k]  = 0;
                m_lock[k] = 1'b0;
                m_ov[k]   = 1'b0;
                m_od[k]   = '0;
                m_oid[k]  = 0;
            end else begin
                g = mgrant(k);
                if (g >= 0 && (!m_ov[k] || s_ordy[k])) begin
                    m_od[k]   = s_data[k][g*W +: W];
                    m_oid[k]  = g;
                    m_ov[k]   = 1'b1;
                    m_cnt[k]  = (m_lock[k] && g == m_last[k]) ? m_cnt[k] + 1 : 1;
                    m_lock[k] = (m_cnt[k] < m_burst[k]);
                    m_last[k] = g;
                    acc[k]    = g;
                end else if (s_ordy[k]) begin
                    m_ov[k] = 1'b0;
                end
            end
        end
    endtask

    // Compare both DUTs mid-cycle, then advance the model across the edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("in_rdy",    k, 32'(o_rdy[k]), 32'(exp_rdy(k)));
            chk("out_valid", k, 32'(o_ov[k]),  32'(m_ov[k]));
            chk("out_data",  k, 32'(o_od[k]),  32'(m_od[k]));
            chk("out_id",    k, 32'(o_id[k]),  32'(m_oid[k]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_all(input logic [N-1:0] v, input logic ordy);
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = v;
            s_ordy[k]  = ordy;
        end
    endtask

    int bseq [7] = '{1, 1, 1, 2, 2, 2, 1};

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) s_data[k] = 32'hD3C2B1A0;
        set_all(4'hF, 1'b1);
        @(posedge clk);
        model_edge();
        #1;

        // Reset held with every channel requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("rst_in_rdy", k, 32'(o_rdy[k]), 0);
                chk("rst_out_valid", k, 32'(o_ov[k]), 0);
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) chk("first_grant_id", k, 32'(o_id[k]), 0);

        // Single stream on channel 2.
        do_reset();
        set_all(4'b0100, 1'b1);
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 2; k++) s_data[k][2*W +: W] = 8'(8'h10 + j);
            tick();
            chk("stream_valid", 0, 32'(o_ov[0]), 1);
            chk("stream_id",    0, 32'(o_id[0]), 2);
            chk("stream_data",  0, 32'(o_od[0]), 32'(8'h10 + j));
        end
        set_all(4'b0000, 1'b1);
        tick();

        // Pure round-robin with all channels requesting.
        do_reset();
        set_all(4'hF, 1'b1);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("rr_valid", 0, 32'(o_ov[0]), 1);
            chk("rr_id",    0, 32'(o_id[0]), 32'(j % N));
        end

        // Backpressure then same-cycle drain and reload.
        do_reset();
        set_all(4'hF, 1'b1);
        tick();
        set_all(4'hF, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("bp_valid",  0, 32'(o_ov[0]), 1);
            chk("bp_id",     0, 32'(o_id[0]), 0);
            chk("bp_data",   0, 32'(o_od[0]), 32'(8'hA0));
            chk("bp_in_rdy", 0, 32'(o_rdy[0]), 0);
        end
        set_all(4'hF, 1'b1);
        tick();
        chk("nobubble_valid", 0, 32'(o_ov[0]), 1);
        chk("nobubble_id",    0, 32'(o_id[0]), 1);

        // Burst lock between channels 1 and 2.
        do_reset();
        set_all(4'b0110, 1'b1);
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("burst_id", 1, 32'(o_id[1]), 32'(bseq[j]));
        end

        // Lock released early when the held channel drops, then reset mid-hold.
        do_reset();
        set_all(4'b0110, 1'b1);
        tick();
        tick();
        chk("rel_pre_id", 1, 32'(o_id[1]), 1);
        set_all(4'b0100, 1'b1);
        tick();
        chk("rel_id", 1, 32'(o_id[1]), 2);
        set_all(4'b0110, 1'b0);
        tick();
        chk("hold_valid", 1, 32'(o_ov[1]), 1);
        rst = 1'b1;
        tick();
        chk("rst_drop_valid", 1, 32'(o_ov[1]), 0);
        rst = 1'b0;
        set_all(4'hF, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) chk("post_rst_id", k, 32'(o_id[k]), 0);

        // Randomized producers honoring the hold-until-accepted rule.
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int ch = 0; ch < N; ch++) begin
                    if (acc[k] == ch) begin
                        s_valid[k][ch] = 1'($urandom_range(0, 1));
                        s_data[k][ch*W +: W] = 8'($urandom);
                    end else if (!s_valid[k][ch] && $urandom_range(0, 2) == 0) begin
                        s_valid[k][ch] = 1'b1;
                        s_data[k][ch*W +: W] = 8'($urandom);
                    end
                end
                s_ordy[k] = ($urandom_range(0, 3) != 0);
            end
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
